// File: rtl/cic_ctrl_pkg.sv
// Shared types and defaults for the CIC decimation sequencing controller.
package cic_ctrl_pkg;

  localparam int unsigned CIC_RW_DEF     = 4;
  localparam int unsigned CIC_SETTLE_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WARM = 2'd1,
    ST_RUN  = 2'd2,
    ST_STOP = 2'd3
  } cic_ctrl_state_t;

endpackage

// File: rtl/cic_stage_div.sv
// One decimation stage: modulo-(div+1) counter that pulses wrap on its terminal advance.
module cic_stage_div
  import cic_ctrl_pkg::*;
#(
  parameter int unsigned RW = CIC_RW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          adv,
  input  logic          clr,
  input  logic [RW-1:0] div,
  output logic          wrap
);

  logic [RW-1:0] cnt;

  assign wrap = adv && (cnt == div);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (adv) begin
      cnt <= wrap ? '0 : cnt + RW'(1);
    end
  end

endmodule

// File: rtl/cic_decim_ctrl.sv
// Sequencing controller for a cascaded CIC decimator: per-stage enables,
// datapath clear on start, start-up transient suppression and output-valid flag.
module cic_decim_ctrl
  import cic_ctrl_pkg::*;
#(
  parameter int unsigned NSTAGE = 2,
  parameter int unsigned RW     = CIC_RW_DEF,
  parameter int unsigned SETTLE = CIC_SETTLE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [NSTAGE*RW-1:0] cfg_div,
  input  logic                 run,
  input  logic                 in_valid,
  output logic [NSTAGE-1:0]    en,
  output logic                 dp_clr,
  output logic                 out_valid,
  output logic                 busy
);

  localparam int unsigned WW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);

  cic_ctrl_state_t             state_q, state_nxt;
  logic [NSTAGE-1:0][RW-1:0]   div_q;
  logic [WW-1:0]               wcnt_q, wcnt_nxt;
  logic [NSTAGE-1:0]           wrap_v;
  logic                        final_wrap;
  logic                        active_c;
  logic                        clr_c;
  logic                        dp_clr_d;
  logic                        ov_d;

  assign cfg_ready = (state_q == ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
    end else if (cfg_valid && cfg_ready) begin
      div_q <= cfg_div;
    end
  end

  // Counters advance only while streaming; an abort from WARM swallows the strobe.
  assign active_c   = (state_q != ST_IDLE) && !((state_q == ST_WARM) && !run);
  assign clr_c      = (state_nxt == ST_IDLE);
  assign final_wrap = wrap_v[NSTAGE-1];

  for (genvar i = 0; i < NSTAGE; i++) begin : g_stage
    logic adv_s;
    logic wrap_s;
    if (i == 0) begin : g_first
      assign adv_s = in_valid && active_c;
    end else begin : g_next
      assign adv_s = g_stage[i-1].wrap_s;
    end
    cic_stage_div #(.RW(RW)) u_div (
      .clk  (clk),
      .rst  (rst),
      .adv  (adv_s),
      .clr  (clr_c),
      .div  (div_q[i]),
      .wrap (wrap_s)
    );
    assign wrap_v[i] = wrap_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE: if (run) state_nxt = ST_WARM;
      ST_WARM: begin
        if (!run) begin
          state_nxt = ST_IDLE;
        end else if (SETTLE == 0) begin
          state_nxt = ST_RUN;
        end else if (final_wrap && ((32'(wcnt_q) + 32'd1) >= SETTLE)) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN:  if (!run) state_nxt = ST_STOP;
      ST_STOP: if (final_wrap) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    dp_clr_d = 1'b0;
    ov_d     = 1'b0;
    wcnt_nxt = wcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (run) begin
          dp_clr_d = 1'b1;
          wcnt_nxt = '0;
        end
      end
      ST_WARM: if (final_wrap) wcnt_nxt = wcnt_q + WW'(1);
      ST_RUN,
      ST_STOP: ov_d = final_wrap;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en        <= '0;
      dp_clr    <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      wcnt_q    <= '0;
    end else begin
      en        <= wrap_v;
      dp_clr    <= dp_clr_d;
      out_valid <= ov_d;
      busy      <= (state_nxt != ST_IDLE);
      wcnt_q    <= wcnt_nxt;
    end
  end

endmodule

// File: tb/tb_cic_decim_ctrl.sv
// Directed bench for cic_decim_ctrl: rate table plus hand-built corner sequences.
module tb_cic_decim_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_div;
  logic       run;
  logic       in_valid;
  logic [1:0] en;
  logic       dp_clr;
  logic       out_valid;
  logic       busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] div;
    int         p;
    int         r;
    int         e_en0;
    int         e_en1;
    int         e_ov;
    int         e_clr;
    int         e_first;
  } vec_t;

  vec_t vecs [4];

  always #5 clk = ~clk;

  cic_decim_ctrl #(.NSTAGE(2), .RW(4), .SETTLE(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_div   (cfg_div),
    .run       (run),
    .in_valid  (in_valid),
    .en        (en),
    .dp_clr    (dp_clr),
    .out_valid (out_valid),
    .busy      (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic iv);
    run      = r;
    in_valid = iv;
    @(posedge clk);
    #1;
  endtask

  task automatic load_cfg(input logic [7:0] d);
    chk("cfg_ready_idle", 32'(cfg_ready), 32'd1);
    cfg_valid = 1'b1;
    cfg_div   = d;
    cyc(1'b0, 1'b0);
    cfg_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (busy && n < 300) begin
      cyc(1'b0, 1'b1);
      n++;
    end
    in_valid = 1'b0;
    chk("drain_timeout", 32'(busy), 32'd0);
  endtask

  task automatic scen(input int idx, input vec_t v);
    int n0 = 0, n1 = 0, nov = 0, nclr = 0, first = 0, bad = 0;
    bit done = 1'b0;
    for (int j = 0; j < 400 && !done; j++) begin
      cyc(j < v.r, (j % v.p) == 0);
      if (en[0]) n0++;
      if (en[1]) begin
        n1++;
        if (out_valid && first == 0) first = n1;
      end
      if (out_valid) nov++;
      if (out_valid && !en[1]) bad++;
      if (dp_clr) nclr++;
      if (j > 0 && !busy) done = 1'b1;
    end
    run      = 1'b0;
    in_valid = 1'b0;
    chk($sformatf("vec%0d_done", idx), 32'(done), 32'd1);
    chk($sformatf("vec%0d_en0", idx), 32'(n0), 32'(v.e_en0));
    chk($sformatf("vec%0d_en1", idx), 32'(n1), 32'(v.e_en1));
    chk($sformatf("vec%0d_ov", idx), 32'(nov), 32'(v.e_ov));
    chk($sformatf("vec%0d_dpclr", idx), 32'(nclr), 32'(v.e_clr));
    chk($sformatf("vec%0d_first_ov", idx), 32'(first), 32'(v.e_first));
    chk($sformatf("vec%0d_ov_wo_en", idx), 32'(bad), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt0, cnt1;
    bit ov_seen, hit;
    logic iv;

    // {div1,div0}, in_valid period, run cycles, en0, en1, out_valid, dp_clr, first out_valid en1 index
    vecs[0] = '{8'h11, 1, 40,  22, 11, 7, 1, 5};
    vecs[1] = '{8'h20, 3, 60,  21,  7, 3, 1, 5};
    vecs[2] = '{8'h33, 1, 100, 28,  7, 3, 1, 5};
    vecs[3] = '{8'h00, 1, 10,  11, 11, 7, 1, 5};

    rst       = 1'b1;
    cfg_valid = 1'b0;
    cfg_div   = 8'h00;
    run       = 1'b0;
    in_valid  = 1'b0;
    #12;
    chk("rst_en", 32'(en), 32'd0);
    chk("rst_dp_clr", 32'(dp_clr), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    #5 rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 4; i++) begin
      load_cfg(vecs[i].div);
      scen(i, vecs[i]);
    end

    // config offered during RUN must wait for IDLE
    load_cfg(8'h11);
    for (int j = 0; j < 30; j++) cyc(1'b1, 1'b1);
    cfg_valid = 1'b1;
    cfg_div   = 8'h33;
    #1;
    chk("run_cfg_ready", 32'(cfg_ready), 32'd0);
    cnt0 = 0;
    cnt1 = 0;
    for (int j = 0; j < 16; j++) begin
      cyc(1'b1, 1'b1);
      if (en[0]) cnt0++;
      if (en[1]) cnt1++;
    end
    chk("run_cfg_en0_rate", 32'(cnt0), 32'd8);
    chk("run_cfg_en1_rate", 32'(cnt1), 32'd4);
    hit = 1'b0;
    for (int j = 0; j < 20 && !hit; j++) begin
      cyc(1'b0, 1'b1);
      if (!busy) begin
        hit = 1'b1;
        chk("stop_final_ov", 32'(out_valid), 32'd1);
        chk("stop_final_en1", 32'(en[1]), 32'd1);
      end
    end
    chk("stop_reached_idle", 32'(hit), 32'd1);
    chk("pending_cfg_ready", 32'(cfg_ready), 32'd1);
    cyc(1'b0, 1'b0);
    cfg_valid = 1'b0;
    scen(4, vecs[2]);

    // abort from WARM after two final-stage pulses
    load_cfg(8'h11);
    ov_seen = 1'b0;
    for (int j = 0; j < 10; j++) begin
      cyc(1'b1, 1'b1);
      if (out_valid) ov_seen = 1'b1;
    end
    cyc(1'b0, 1'b1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_en", 32'(en), 32'd0);
    chk("abort_ov", 32'(out_valid), 32'd0);
    chk("abort_ov_never", 32'(ov_seen), 32'd0);
    cyc(1'b1, 1'b1);
    chk("restart_dp_clr", 32'(dp_clr), 32'd1);
    cyc(1'b1, 1'b1);
    chk("restart_cnt_cleared", 32'(en), 32'd0);
    cyc(1'b1, 1'b1);
    chk("restart_first_en0", 32'(en), 32'd1);
    drain();

    // asynchronous reset mid-RUN
    load_cfg(8'h11);
    for (int j = 0; j < 29; j++) cyc(1'b1, 1'b1);
    chk("pre_rst_ov", 32'(out_valid), 32'd1);
    chk("pre_rst_en", 32'(en), 32'd3);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_en", 32'(en), 32'd0);
    chk("async_rst_ov", 32'(out_valid), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_cfg_ready", 32'(cfg_ready), 32'd1);
    run      = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    cyc(1'b1, 1'b0);
    chk("post_rst_dp_clr", 32'(dp_clr), 32'd1);
    for (int j = 1; j <= 10; j++) begin
      iv = (j % 3) != 0;
      cyc(1'b1, iv);
      chk($sformatf("passthru_en_%0d", j), 32'(en), iv ? 32'd3 : 32'd0);
    end
    drain();

    // config accepted in the same cycle as the start request
    chk("same_cyc_cfg_ready", 32'(cfg_ready), 32'd1);
    cfg_valid = 1'b1;
    cfg_div   = 8'h02;
    cyc(1'b1, 1'b1);
    cfg_valid = 1'b0;
    chk("same_cyc_dp_clr", 32'(dp_clr), 32'd1);
    chk("same_cyc_busy", 32'(busy), 32'd1);
    for (int j = 1; j <= 12; j++) begin
      cyc(1'b1, 1'b1);
      chk($sformatf("same_cyc_en_%0d", j), 32'(en), (j % 3 == 0) ? 32'd3 : 32'd0);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cic_decim_ctrl.md
# cic_decim_ctrl

Sequencing controller for the multi-stage CIC decimation chain. It turns the source sample strobe into the cascaded per-stage enables that the CIC downsampler consumes, for example the ÷2 and ÷4 enables of a two-stage chain. It also clears the datapath on start, suppresses the start-up transient outputs, and flags valid decimated samples. Decimation ratios are loaded over a valid/ready config port while the chain is idle.

## Interface
- `NSTAGE`, default 2: number of decimation stages (enables generated).
- `RW`, default 4: width of each per-stage divide field.
- `SETTLE`, default 4: number of final-stage strobes discarded after start.
- `clk`, in, 1: single clock; all logic on rising edge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `cfg_valid`, in, 1: config offer.
- `cfg_ready`, out, 1: high only in IDLE.
- `cfg_div`, in, NSTAGE*RW: field i = stage i divide minus 1 (0 = pass-through).
- `run`, in, 1: level request to stream.
- `in_valid`, in, 1: source sample strobe.
- `en`, out, NSTAGE: registered per-stage enables, one-cycle pulses.
- `dp_clr`, out, 1: one-cycle synchronous clear to the CIC integrators/combs.
- `out_valid`, out, 1: final-stage output sample is valid this cycle.
- `busy`, out, 1: state != IDLE.

## Operation
- States: IDLE, WARM, RUN, STOP.
- Config handshake:
  - A config is accepted on `cfg_valid && cfg_ready` and registered into `div[i]`.
  - `cfg_valid` is ignored outside IDLE; the offer stays pending until IDLE is reached.
- Stage counters `cnt[i]`, range 0..`div[i]`:
  - Stage 0 advances on `in_valid`. Stage i>0 advances when stage i-1 wraps.
  - An advance with `cnt==div` wraps to 0 and pulses the stage. Any other advance increments.
  - All stages that wrap from one `in_valid` pulse in the same cycle.
- Counters only run in WARM, RUN and STOP. They are forced to 0 in IDLE.
- IDLE + `run`:
  - Pulse `dp_clr`, enter WARM, clear the warm counter.
  - `in_valid` in that cycle is ignored.
  - If the config handshake fires in the same cycle, the new `div` values are in use from WARM entry.
- WARM:
  - `en` is driven normally and `out_valid` stays 0.
  - Each final-stage pulse increments the warm counter. At SETTLE pulses, enter RUN.
  - `run` low in WARM returns to IDLE at once, with no output.
- RUN:
  - `out_valid` equals `en[NSTAGE-1]`.
  - `run` low enters STOP.
- STOP:
  - Keeps strobing until the next final-stage pulse.
  - That pulse is delivered with `out_valid=1`, then IDLE.
  - `run` re-asserted during STOP is ignored until IDLE.
- Reset: state IDLE; `cnt`, `div`, warm counter, `en`, `dp_clr`, `out_valid`, `busy` all 0; `cfg_ready`=1.

## Timing
- Latency: `en`/`out_valid` assert in cycle k+1 for an `in_valid` sampled in cycle k.
- `dp_clr` asserts the cycle after `run` is sampled high in IDLE. `busy` rises in the same cycle.
- `cfg_ready` is decoded combinationally from the state register.
- Overall output rate is one `out_valid` per prod(`div[i]`+1) `in_valid` pulses.
- Boundary cases:
  - Back-to-back `in_valid` is legal.
  - `in_valid` idle for any time freezes the counters; no timeout.
  - An asynchronous `rst` mid-stream drops all pulses immediately. There is no partial output and the config must be reloaded.
  - SETTLE=0: the WARM→RUN transition happens on the first cycle of WARM.

## Structure
- Package `cic_ctrl_pkg` holds:
  - the state typedef `cic_ctrl_state_t`;
  - the default `SETTLE` and `RW` localparams.
- Sub-module `cic_stage_div`: one per-stage counter with inputs `adv`, `clr` and `div`, and output `wrap`.
  - Instanced NSTAGE times via generate; `wrap` of stage i drives `adv` of stage i+1.
- The top level holds the FSM, warm counter and output registers.

## Test plan
- div={1,1}, continuous `in_valid`, `run`=1 → `en[0]` every 2 cycles and `en[1]` every 4 (the ÷2/÷4 pattern), coincident on shared cycles. Exactly one `dp_clr` pulse. First `out_valid` on the 5th `en[1]` pulse (SETTLE=4).
- `in_valid` every 3rd cycle with div={0,2} → `en[0]` mirrors `in_valid` delayed by 1 cycle; `en[1]` appears on every 3rd `in_valid`, i.e. every 9 cycles.
- `cfg_valid` asserted in RUN with div={3,3} → `cfg_ready`=0 and the rate is unchanged. After `run` low, the STOP pulse still gives `out_valid`=1. In IDLE the config is accepted, and the next run strobes `en[1]` every 16 `in_valid`.
- `run` dropped in WARM after 2 final pulses → IDLE next cycle; `out_valid` never asserts; counters are 0.
- `rst` asserted mid-RUN (asynchronously, between edges) → all outputs 0 immediately and `div`=0. After release, `run` alone gives pass-through (`en` = delayed `in_valid`).
- `run` and `cfg_valid` in the same IDLE cycle with div={2,0} → new config is used from WARM; `en[0]` every 3 `in_valid`, and `en[1]` equals `en[0]`.
